// File: rtl/nxor_reduce_pipe.sv
// Pipelined per-lane XNOR reduction of N operands with a valid/ready stream.
// Define NXOR_REDUCE_ACCUM_EN to fold each frame into one output beat on I_LAST.
module nxor_reduce_pipe #(
    parameter int N     = 4,
    parameter int WIDTH = 2
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [N*WIDTH-1:0]   I,
    input  logic                 I_VALID,
    input  logic                 I_LAST,
    output logic                 I_READY,
    output logic [WIDTH-1:0]     O,
    output logic                 O_VALID,
    output logic                 O_LAST,
    input  logic                 O_READY
);

    function automatic int calc_stages(input int n);
        int s;
        int c;
        s = 0;
        c = n;
        while (c > 1) begin
            c = (c + 3) / 4;
            s++;
        end
        if (s < 1) s = 1;
        return s;
    endfunction

    localparam int STAGES = calc_stages(N);

    typedef logic [N-1:0][WIDTH-1:0] terms_t;

    terms_t             w_stage [STAGES];
    logic [STAGES-1:0]  w_vld;
    logic [STAGES-1:0]  w_last;
    logic               w_adv;
    logic [WIDTH-1:0]   w_beat;

    logic [WIDTH-1:0]   r_o;
    logic               r_ov;
    logic               r_ol;

    // One global enable: the whole pipe freezes while the output is held.
    assign w_adv   = ~r_ov | O_READY;
    assign I_READY = w_adv;

    assign w_stage[0] = I;
    assign w_vld[0]   = I_VALID;
    assign w_last[0]  = I_LAST;

    // Intermediate stages: groups of 4 terms; entries past the live count stay 0.
    for (genvar s = 1; s < STAGES; s++) begin : g_stage
        terms_t w_x;
        terms_t r_d;
        logic   r_v;
        logic   r_l;

        for (genvar g = 0; g < N; g++) begin : g_grp
            logic [3:0][WIDTH-1:0] w_t;
            for (genvar j = 0; j < 4; j++) begin : g_t
                if (4*g + j < N) begin : g_live
                    assign w_t[j] = w_stage[s-1][4*g + j];
                end else begin : g_pad
                    assign w_t[j] = '0;
                end
            end
            assign w_x[g] = w_t[0] ^ w_t[1] ^ w_t[2] ^ w_t[3];
        end

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                r_d <= '0;
                r_v <= 1'b0;
                r_l <= 1'b0;
            end else if (w_adv) begin
                r_d <= w_x;
                r_v <= w_vld[s-1];
                r_l <= w_last[s-1];
            end
        end

        assign w_stage[s] = r_d;
        assign w_vld[s]   = r_v;
        assign w_last[s]  = r_l;
    end

    // Final group: at most 4 live terms remain, the rest are zero padding.
    for (genvar k = 0; k < N; k++) begin : g_red
        logic [WIDTH-1:0] w_acc;
        if (k == 0) begin : g_first
            assign w_acc = w_stage[STAGES-1][0];
        end else begin : g_next
            assign w_acc = g_red[k-1].w_acc ^ w_stage[STAGES-1][k];
        end
    end

    assign w_beat = g_red[N-1].w_acc;

`ifdef NXOR_REDUCE_ACCUM_EN
    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_o   <= '0;
            r_ov  <= 1'b0;
            r_ol  <= 1'b0;
            r_acc <= '0;
        end else if (w_adv) begin
            r_ov <= w_vld[STAGES-1] & w_last[STAGES-1];
            r_ol <= w_vld[STAGES-1] & w_last[STAGES-1];
            if (w_vld[STAGES-1]) begin
                if (w_last[STAGES-1]) begin
                    r_o   <= ~(r_acc ^ w_beat);
                    r_acc <= '0;
                end else begin
                    r_acc <= r_acc ^ w_beat;
                end
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_o  <= '0;
            r_ov <= 1'b0;
            r_ol <= 1'b0;
        end else if (w_adv) begin
            r_ov <= w_vld[STAGES-1];
            r_ol <= w_vld[STAGES-1] & w_last[STAGES-1];
            if (w_vld[STAGES-1]) r_o <= ~w_beat;
        end
    end
`endif

    assign O       = r_o;
    assign O_VALID = r_ov;
    assign O_LAST  = r_ol;

endmodule

// File: tb/tb_nxor_reduce_pipe.sv
// Scoreboard bench for nxor_reduce_pipe: three configurations (4x2, 16x8, 5x1).
module tb_nxor_reduce_pipe;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int ncyc   = 0;
    logic lat_chk;
    logic [7:0] macc;

    // DUT A: N=4, W=2 (one stage)
    logic [7:0] a_i;  logic a_iv, a_il, a_ir, a_ov, a_ol, a_or;  logic [1:0] a_o;
    // DUT B: N=16, W=8 (two stages)
    logic [127:0] b_i; logic b_iv, b_il, b_ir, b_ov, b_ol, b_or; logic [7:0] b_o;
    // DUT C: N=5, W=1 (two stages, padded tree)
    logic [4:0] c_i;  logic c_iv, c_il, c_ir, c_ov, c_ol, c_or;  logic [0:0] c_o;

    nxor_reduce_pipe #(.N(4), .WIDTH(2)) u_a (
        .CLK(clk), .RESETN(rstn), .I(a_i), .I_VALID(a_iv), .I_LAST(a_il), .I_READY(a_ir),
        .O(a_o), .O_VALID(a_ov), .O_LAST(a_ol), .O_READY(a_or));
    nxor_reduce_pipe #(.N(16), .WIDTH(8)) u_b (
        .CLK(clk), .RESETN(rstn), .I(b_i), .I_VALID(b_iv), .I_LAST(b_il), .I_READY(b_ir),
        .O(b_o), .O_VALID(b_ov), .O_LAST(b_ol), .O_READY(b_or));
    nxor_reduce_pipe #(.N(5), .WIDTH(1)) u_c (
        .CLK(clk), .RESETN(rstn), .I(c_i), .I_VALID(c_iv), .I_LAST(c_il), .I_READY(c_ir),
        .O(c_o), .O_VALID(c_ov), .O_LAST(c_ol), .O_READY(c_or));

    logic [2:0] qa[$];
    logic [8:0] qb[$];
    int         qbc[$];
    logic [1:0] qc[$];

    typedef struct { logic [7:0] i; logic [1:0] o; } veca_t;
    typedef struct { logic [4:0] i; logic [0:0] o; } vecc_t;
    veca_t va [6];
    vecc_t vc [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_run++;
        n_fail++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic logic [7:0] gold16(input logic [127:0] v);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < 16; k++) x ^= v[k*8 +: 8];
        return x;
    endfunction

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(negedge clk) begin : mon_a
        logic [2:0] e;
        if (rstn && a_ov && a_or) begin
            if (qa.size() == 0) flag("a_unexpected_beat");
            else begin
                e = qa.pop_front();
                chk("a_data", 32'(a_o), 32'(e[1:0]));
                chk("a_last", 32'(a_ol), 32'(e[2]));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [8:0] e;
        int c;
        if (rstn && b_ov && b_or) begin
            if (qb.size() == 0) flag("b_unexpected_beat");
            else begin
                e = qb.pop_front();
                c = qbc.pop_front();
                chk("b_data", 32'(b_o), 32'(e[7:0]));
                chk("b_last", 32'(b_ol), 32'(e[8]));
                if (lat_chk) chk("b_latency", 32'(ncyc - c), 32'd2);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        logic [1:0] e;
        if (rstn && c_ov && c_or) begin
            if (qc.size() == 0) flag("c_unexpected_beat");
            else begin
                e = qc.pop_front();
                chk("c_data", 32'(c_o), 32'(e[0]));
                chk("c_last", 32'(c_ol), 32'(e[1]));
            end
        end
    end

    task automatic senda(input logic [7:0] d, input logic [1:0] e);
        int t = 0;
        a_i = d; a_il = 1'b1; a_iv = 1'b1;
        @(negedge clk);
        while (!a_ir && t < 100) begin @(negedge clk); t++; end
        if (a_ir) qa.push_back({1'b1, e});
        else flag("a_input_timeout");
        @(posedge clk); #1;
        a_iv = 1'b0;
    endtask

    task automatic sendc(input logic [4:0] d, input logic [0:0] e);
        int t = 0;
        c_i = d; c_il = 1'b1; c_iv = 1'b1;
        @(negedge clk);
        while (!c_ir && t < 100) begin @(negedge clk); t++; end
        if (c_ir) qc.push_back({1'b1, e});
        else flag("c_input_timeout");
        @(posedge clk); #1;
        c_iv = 1'b0;
    endtask

    // Reference model lives here: expected result is pushed when the beat is accepted.
    task automatic sendb(input logic [127:0] d, input logic l);
        int t = 0;
        logic [7:0] x;
        b_i = d; b_il = l; b_iv = 1'b1;
        @(negedge clk);
        while (!b_ir && t < 100) begin @(negedge clk); t++; end
        if (b_ir) begin
            x = gold16(d);
`ifdef NXOR_REDUCE_ACCUM_EN
            macc = macc ^ x;
            if (l) begin
                qb.push_back({1'b1, ~macc});
                qbc.push_back(ncyc);
                macc = '0;
            end
`else
            qb.push_back({l, ~x});
            qbc.push_back(ncyc);
`endif
        end else flag("b_input_timeout");
        @(posedge clk); #1;
        b_iv = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && t < 100) begin
            @(negedge clk); t++;
        end
        chk("drain_pending", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_a_ovalid"}, 32'(a_ov), 32'd0);
        chk({tag, "_a_o"},      32'(a_o),  32'd0);
        chk({tag, "_a_olast"},  32'(a_ol), 32'd0);
        chk({tag, "_a_iready"}, 32'(a_ir), 32'd1);
        chk({tag, "_b_ovalid"}, 32'(b_ov), 32'd0);
        chk({tag, "_b_o"},      32'(b_o),  32'd0);
        chk({tag, "_b_olast"},  32'(b_ol), 32'd0);
        chk({tag, "_b_iready"}, 32'(b_ir), 32'd1);
        chk({tag, "_c_ovalid"}, 32'(c_ov), 32'd0);
        chk({tag, "_c_o"},      32'(c_o),  32'd0);
        chk({tag, "_c_iready"}, 32'(c_ir), 32'd1);
    endtask

    initial begin
        logic [127:0] x1, x2, x3;
        int t0;

        va[0] = '{8'b00_11_10_01, 2'b11};
        va[1] = '{8'b00_00_00_01, 2'b10};
        va[2] = '{8'hFF,          2'b11};
        va[3] = '{8'h00,          2'b11};
        va[4] = '{8'b00_00_00_11, 2'b00};
        va[5] = '{8'b10_00_00_00, 2'b01};
        vc[0] = '{5'b00001, 1'b0};
        vc[1] = '{5'b00000, 1'b1};
        vc[2] = '{5'b10000, 1'b0};
        vc[3] = '{5'b11000, 1'b1};
        vc[4] = '{5'b11111, 1'b0};

        rstn = 1'b0; lat_chk = 1'b0; macc = '0;
        a_i = '0; a_iv = 0; a_il = 0; a_or = 1;
        b_i = '0; b_iv = 0; b_il = 0; b_or = 1;
        c_i = '0; c_iv = 0; c_il = 0; c_or = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven single-stage and padded-tree vectors, streamed back to back
        for (int k = 0; k < 6; k++) senda(va[k].i, va[k].o);
        for (int k = 0; k < 5; k++) sendc(vc[k].i, vc[k].o);
        drain();

        // Random full-rate stream with latency and throughput checks
        lat_chk = 1'b1;
        t0 = ncyc;
        for (int k = 0; k < 1000; k++)
            sendb({$urandom(), $urandom(), $urandom(), $urandom()},
                  (k == 999) ? 1'b1 : ($urandom_range(0, 3) == 0));
        chk("b_throughput_cycles", 32'(ncyc - t0), 32'd1000);
        drain();
        lat_chk = 1'b0;

        // Backpressure: two beats fill the pipe, a third waits for release
        x1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        x2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        x3 = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_or = 1'b0;
        sendb(x1, 1'b1);
        sendb(x2, 1'b1);
        fork
            sendb(x3, 1'b1);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_iready", 32'(b_ir), 32'd0);
                    chk("stall_ovalid", 32'(b_ov), 32'd1);
                    chk("stall_hold_o", 32'(b_o), 32'(qb[0][7:0]));
                    chk("stall_pending", 32'(qb.size()), 32'd2);
                end
                @(posedge clk); #1;
                b_or = 1'b1;
            end
        join
        drain();

`ifdef NXOR_REDUCE_ACCUM_EN
        // Three-beat frame with xor 1,1,1 then a single all-zero frame
        sendb({120'b0, 8'h01}, 1'b0);
        sendb({120'b0, 8'h01}, 1'b0);
        sendb({120'b0, 8'h01}, 1'b1);
        drain();
        sendb('0, 1'b1);
        drain();
`endif

        // Reset with two beats in flight, then a fresh beat must be the first out
        sendb({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        sendb({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        rstn = 1'b0;
        qa.delete(); qb.delete(); qbc.delete(); qc.delete();
        macc = '0;
        #1;
        chk_idle("midreset");
        @(posedge clk); #1;
        rstn = 1'b1;
        sendb({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_quiet", 32'(b_ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
